tis_decode_stage: RTL and testbench
===================================

# tis_decode_stage

Registered, parametrised instruction-decode stage for the TIS node datapath. It sits between program fetch and execute. It accepts raw instruction words over a valid/ready handshake and splits them into control fields (pc, ALU, register, mux selects, port indices, sign-extended constant). A 2-entry skid buffer lets execute stall (e.g. on a blocked port read) without dropping words, and a flush clears in-flight words on taken jumps. Compared with the single combinational decoder, it adds configurable constant width and port count, pipelining, back-pressure and illegal-opcode reporting.

## Interface
- CONST_W, 11: constant field width; instruction width INSTR_W = CONST_W + 10
- NUM_PORTS, 4: number of neighbour ports, range 1..4
- PORT_W, 2: port index width, fixed at 2
- clk  in  1  clock, rising-edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- in_valid  in  1  fetch word valid
- in_ready  out  1  stage can accept a word
- in_instr  in  INSTR_W  fields: opcode [INSTR_W-1:INSTR_W-4]; src [CONST_W+5:CONST_W+3]; dst [CONST_W+2:CONST_W]; const [CONST_W-1:0]
- flush  in  1  discard all buffered words
- out_valid  out  1  decoded word valid
- out_ready  in  1  execute accepts word
- out_const  out  CONST_W  signed immediate, passed through
- pc_instr  out  4  0 INC, 1 JMP, 2 JEZ, 3 JNZ, 4 JGZ, 5 JLZ, 6 JRO
- alu_instr  out  2  0 PASS, 1 ADD, 2 SUB, 3 NEG
- registers_instr  out  2  0 NONE, 1 WR_ACC, 2 SWP, 3 SAV
- in_mux_sel  out  2  0 NIL, 1 ACC, 2 IMM, 3 PORT
- in_port  out  PORT_W  source port index when in_mux_sel=3
- out_mux_sel  out  1  0 write ACC/NIL, 1 write port
- out_port  out  PORT_W  destination port index
- illegal  out  1  sticky, set on an illegal word
- illegal_cnt  out  8  saturating count of illegal words

## Operation
- Opcodes: 0 NOP, 1 MOV, 2 SWP, 3 SAV, 4 ADD, 5 SUB, 6 NEG, 7 JMP, 8 JEZ, 9 JNZ, 10 JGZ, 11 JLZ, 12 JRO. Opcodes 13–15 are illegal.
- src encoding: 0 NIL, 1 ACC, 2 IMM, 3+k port k.
  - src is used by MOV, ADD, SUB and JRO.
  - src ≥ 3+NUM_PORTS is illegal.
- dst encoding: 0 NIL, 1 ACC, 2+k port k.
  - dst is used by MOV only.
  - dst ≥ 2+NUM_PORTS is illegal.
- MOV field values:
  - dst ACC: registers_instr=WR_ACC, alu=PASS, out_mux_sel=0.
  - dst port: registers_instr=NONE, out_mux_sel=1.
  - dst NIL: registers_instr=NONE, out_mux_sel=0.
- ADD/SUB: alu_instr set accordingly, registers_instr=WR_ACC.
- NEG: alu_instr=NEG, registers_instr=WR_ACC, in_mux_sel=NIL.
- SWP/SAV: registers_instr set accordingly.
- Jumps: pc_instr set accordingly, registers_instr=NONE. out_const carries the target or offset; JRO takes its offset from src.
- Illegal words decode as NOP (all fields 0).
  - illegal is set and illegal_cnt increments when the word is accepted at the input.
  - illegal_cnt saturates at 255.
- Decode is combinational on in_instr. The result is written into the skid buffer as a field bundle.
- Skid buffer: 2 entries, FIFO order.
  - Outputs always present the head entry.
  - out_valid = buffer non-empty.
- Unused fields are 0: in_port/out_port when not selected, out_const for opcodes with no IMM source and no jump.

## Timing
- Reset (rst_n=0, asynchronous):
  - out_valid=0, in_ready=0, illegal=0, illegal_cnt=0.
  - All decoded outputs = 0.
  - in_ready goes to 1 on the first clk edge after rst_n rises.
- Latency: a word accepted at edge N (in_valid & in_ready) is visible with out_valid=1 after edge N.
- Throughput: 1 word/cycle while out_ready=1.
- in_ready is registered. It is 0 exactly when both entries are full.
- Simultaneous push and pop while full is not possible, because in_ready=0. Push and pop with 1 entry keeps the count at 1.
- Output fields hold stable while out_valid & !out_ready.
- flush has priority over push and pop in the same cycle:
  - Both entries are cleared.
  - The same-cycle input beat is dropped and not counted as illegal.
  - out_valid=0 and in_ready=1 on the next cycle.
- The illegal flags are not cleared by flush; they are cleared only by reset.
- Asserting reset mid-stream discards all entries immediately.

## Structure
- Shared package tis_pkg holds:
  - opcode, pc_instr, alu_instr, registers_instr and in_mux_sel enumerations;
  - src/dst base constants (IMM=2, PORT_BASE_SRC=3, PORT_BASE_DST=2);
  - the decoded-bundle struct.
- Sub-module tis_op_fields: the pure combinational field decoder, reusable by the single-cycle path.
- Top level: the skid buffer, handshake logic and illegal counters.

## Test plan
- Reset, then MOV 5, ACC (opcode 1, src 2, dst 1, const 5) with out_ready=1:
  - next cycle out_valid=1, in_mux_sel=2, out_const=5, registers_instr=1, pc_instr=0.
- out_ready=0 while pushing 3 words:
  - in_ready drops after the 2nd is accepted.
  - The 3rd is held off.
  - Releasing out_ready yields words 1, 2, 3 in order with unchanged fields.
- ADD from port 3 with NUM_PORTS=4: in_mux_sel=3, in_port=3, alu_instr=1.
  - Same word with NUM_PORTS=2: decodes as NOP, illegal=1, illegal_cnt=1.
- JRO with src IMM, const=-3: pc_instr=6, out_const=-3 (0x7FD for CONST_W=11).
- flush with 2 entries buffered and in_valid=1:
  - next cycle out_valid=0, in_ready=1.
  - The dropped beat is never output.
- Push 300 opcode-15 words: illegal_cnt saturates at 255.
  - Asserting rst_n=0 mid-burst clears out_valid and the counters asynchronously.

Source files
------------

// File: rtl/tis_pkg.sv
// Shared definitions for the TIS node decode path.
// Holds the opcode and control-field enumerations, the src/dst base
// encodings and the decoded field bundle. The immediate is carried beside
// the bundle because its width is a per-instance parameter.
package tis_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_MOV = 4'd1,
        OP_SWP = 4'd2,
        OP_SAV = 4'd3,
        OP_ADD = 4'd4,
        OP_SUB = 4'd5,
        OP_NEG = 4'd6,
        OP_JMP = 4'd7,
        OP_JEZ = 4'd8,
        OP_JNZ = 4'd9,
        OP_JGZ = 4'd10,
        OP_JLZ = 4'd11,
        OP_JRO = 4'd12
    } opcode_e;

    typedef enum logic [3:0] {
        PC_INC = 4'd0,
        PC_JMP = 4'd1,
        PC_JEZ = 4'd2,
        PC_JNZ = 4'd3,
        PC_JGZ = 4'd4,
        PC_JLZ = 4'd5,
        PC_JRO = 4'd6
    } pc_instr_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2,
        ALU_NEG  = 2'd3
    } alu_instr_e;

    typedef enum logic [1:0] {
        REG_NONE   = 2'd0,
        REG_WR_ACC = 2'd1,
        REG_SWP    = 2'd2,
        REG_SAV    = 2'd3
    } reg_instr_e;

    typedef enum logic [1:0] {
        IN_NIL  = 2'd0,
        IN_ACC  = 2'd1,
        IN_IMM  = 2'd2,
        IN_PORT = 2'd3
    } in_mux_e;

    localparam int unsigned TIS_PORT_W = 2;

    localparam logic [2:0] SRC_NIL       = 3'd0;
    localparam logic [2:0] SRC_ACC       = 3'd1;
    localparam logic [2:0] SRC_IMM       = 3'd2;
    localparam logic [2:0] PORT_BASE_SRC = 3'd3;
    localparam logic [2:0] DST_NIL       = 3'd0;
    localparam logic [2:0] DST_ACC       = 3'd1;
    localparam logic [2:0] PORT_BASE_DST = 3'd2;

    typedef struct packed {
        pc_instr_e             pc;
        alu_instr_e            alu;
        reg_instr_e            regs;
        in_mux_e               in_mux;
        logic [TIS_PORT_W-1:0] in_port;
        logic                  out_mux;
        logic [TIS_PORT_W-1:0] out_port;
    } dec_fields_t;

endpackage

// File: rtl/tis_op_fields.sv
// Pure combinational TIS field decoder.
// Ports:
//   instr      in   raw word {opcode[3:0], src[2:0], dst[2:0], const}
//   fields     out  decoded control bundle
//   const_val  out  immediate when used as source or jump target, else 0
//   illegal    out  opcode or an in-use src/dst outside the legal range
// An illegal word decodes to all-zero fields (a NOP).
module tis_op_fields
    import tis_pkg::*;
#(
    parameter int CONST_W   = 11,
    parameter int NUM_PORTS = 4
) (
    input  logic [CONST_W+9:0] instr,
    output dec_fields_t        fields,
    output logic [CONST_W-1:0] const_val,
    output logic               illegal
);

    localparam logic [3:0] SRC_LIMIT = 4'(int'(PORT_BASE_SRC) + NUM_PORTS);
    localparam logic [3:0] DST_LIMIT = 4'(int'(PORT_BASE_DST) + NUM_PORTS);

    opcode_e            opcode;
    logic [2:0]         src;
    logic [2:0]         dst;
    logic [CONST_W-1:0] imm;
    logic [2:0]         src_off;
    logic [2:0]         dst_off;
    logic               src_bad;
    logic               dst_bad;
    logic               use_src;
    in_mux_e            src_mux;

    assign opcode  = opcode_e'(instr[CONST_W+9:CONST_W+6]);
    assign src     = instr[CONST_W+5:CONST_W+3];
    assign dst     = instr[CONST_W+2:CONST_W];
    assign imm     = instr[CONST_W-1:0];
    assign src_off = src - PORT_BASE_SRC;
    assign dst_off = dst - PORT_BASE_DST;
    assign src_bad = ({1'b0, src} >= SRC_LIMIT);
    assign dst_bad = ({1'b0, dst} >= DST_LIMIT);

    always_comb begin
        case (src)
            SRC_NIL: src_mux = IN_NIL;
            SRC_ACC: src_mux = IN_ACC;
            SRC_IMM: src_mux = IN_IMM;
            default: src_mux = IN_PORT;
        endcase
    end

    always_comb begin
        fields    = '0;
        const_val = '0;
        illegal   = 1'b0;
        use_src   = 1'b0;

        case (opcode)
            OP_NOP: ;
            OP_MOV: begin
                use_src = 1'b1;
                if (dst_bad) begin
                    illegal = 1'b1;
                end else if (dst == DST_ACC) begin
                    fields.regs = REG_WR_ACC;
                    fields.alu  = ALU_PASS;
                end else if (dst >= PORT_BASE_DST) begin
                    fields.out_mux  = 1'b1;
                    fields.out_port = dst_off[TIS_PORT_W-1:0];
                end
            end
            OP_SWP: fields.regs = REG_SWP;
            OP_SAV: fields.regs = REG_SAV;
            OP_ADD: begin
                use_src     = 1'b1;
                fields.alu  = ALU_ADD;
                fields.regs = REG_WR_ACC;
            end
            OP_SUB: begin
                use_src     = 1'b1;
                fields.alu  = ALU_SUB;
                fields.regs = REG_WR_ACC;
            end
            OP_NEG: begin
                fields.alu  = ALU_NEG;
                fields.regs = REG_WR_ACC;
            end
            OP_JMP: begin fields.pc = PC_JMP; const_val = imm; end
            OP_JEZ: begin fields.pc = PC_JEZ; const_val = imm; end
            OP_JNZ: begin fields.pc = PC_JNZ; const_val = imm; end
            OP_JGZ: begin fields.pc = PC_JGZ; const_val = imm; end
            OP_JLZ: begin fields.pc = PC_JLZ; const_val = imm; end
            OP_JRO: begin
                use_src   = 1'b1;
                fields.pc = PC_JRO;
            end
            default: illegal = 1'b1;
        endcase

        // Source routing is shared by MOV, ADD, SUB and JRO; the immediate
        // only appears on out_const when it is actually the selected source.
        if (use_src) begin
            if (src_bad) begin
                illegal = 1'b1;
            end else begin
                fields.in_mux = src_mux;
                if (src_mux == IN_PORT) begin
                    fields.in_port = src_off[TIS_PORT_W-1:0];
                end
                if (src_mux == IN_IMM) begin
                    const_val = imm;
                end
            end
        end

        if (illegal) begin
            fields    = '0;
            const_val = '0;
        end
    end

endmodule

// File: rtl/tis_decode_stage.sv
// Registered TIS instruction-decode stage with a 2-entry skid buffer.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready/in_instr     fetch-side handshake and raw word
//   flush                          drop all buffered words and the same-cycle beat
//   out_valid/out_ready            execute-side handshake
//   out_const, pc_instr, alu_instr, registers_instr,
//   in_mux_sel, in_port, out_mux_sel, out_port   head-entry decoded fields
//   illegal, illegal_cnt           sticky flag / saturating count of illegal words
module tis_decode_stage
    import tis_pkg::*;
#(
    parameter int CONST_W   = 11,
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CONST_W+9:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CONST_W-1:0] out_const,
    output logic [3:0]         pc_instr,
    output logic [1:0]         alu_instr,
    output logic [1:0]         registers_instr,
    output logic [1:0]         in_mux_sel,
    output logic [PORT_W-1:0]  in_port,
    output logic               out_mux_sel,
    output logic [PORT_W-1:0]  out_port,
    output logic               illegal,
    output logic [7:0]         illegal_cnt
);

    dec_fields_t        dec_fields;
    logic [CONST_W-1:0] dec_const;
    logic               dec_illegal;

    // Entry 0 is always the head; entry 1 shifts down on a pop.
    dec_fields_t        f0, f1;
    logic [CONST_W-1:0] c0, c1;
    logic [1:0]         count;
    logic [1:0]         count_next;
    logic               ready_q;
    logic               push;
    logic               pop;

    tis_op_fields #(
        .CONST_W   (CONST_W),
        .NUM_PORTS (NUM_PORTS)
    ) u_fields (
        .instr     (in_instr),
        .fields    (dec_fields),
        .const_val (dec_const),
        .illegal   (dec_illegal)
    );

    assign push = in_valid & ready_q & ~flush;
    assign pop  = (count != 2'd0) & out_ready & ~flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = 2'd0;
        end else if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f0      <= '0;
            f1      <= '0;
            c0      <= '0;
            c1      <= '0;
            count   <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
            if (flush) begin
                f0 <= '0;
                f1 <= '0;
                c0 <= '0;
                c1 <= '0;
            end else if (pop) begin
                // Push with a pop only happens at count 1: the new word
                // becomes the head directly.
                if (push) begin
                    f0 <= dec_fields;
                    c0 <= dec_const;
                end else begin
                    f0 <= f1;
                    c0 <= c1;
                    f1 <= '0;
                    c1 <= '0;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    f0 <= dec_fields;
                    c0 <= dec_const;
                end else begin
                    f1 <= dec_fields;
                    c1 <= dec_const;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else if (push && dec_illegal) begin
            illegal <= 1'b1;
            if (illegal_cnt != 8'hFF) begin
                illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end

    assign in_ready        = ready_q;
    assign out_valid       = (count != 2'd0);
    assign out_const       = c0;
    assign pc_instr        = f0.pc;
    assign alu_instr       = f0.alu;
    assign registers_instr = f0.regs;
    assign in_mux_sel      = f0.in_mux;
    assign in_port         = f0.in_port;
    assign out_mux_sel     = f0.out_mux;
    assign out_port        = f0.out_port;

endmodule

// File: tb/tb_tis_decode_stage.sv
module tb_tis_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [20:0] in_instr;
    logic [10:0] out_const;
    logic [3:0]  pc_instr;
    logic [1:0]  alu_instr, registers_instr, in_mux_sel, in_port, out_port;
    logic        out_mux_sel, illegal;
    logic [7:0]  illegal_cnt;

    logic        d2_in_valid, d2_in_ready, d2_flush, d2_out_valid, d2_out_ready;
    logic [20:0] d2_instr;
    logic [10:0] d2_out_const;
    logic [3:0]  d2_pc;
    logic [1:0]  d2_alu, d2_regs, d2_in_mux, d2_in_port, d2_out_port;
    logic        d2_out_mux, d2_illegal;
    logic [7:0]  d2_illegal_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    tis_decode_stage #(.CONST_W(11), .NUM_PORTS(4), .PORT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_const(out_const), .pc_instr(pc_instr), .alu_instr(alu_instr),
        .registers_instr(registers_instr), .in_mux_sel(in_mux_sel),
        .in_port(in_port), .out_mux_sel(out_mux_sel), .out_port(out_port),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    tis_decode_stage #(.CONST_W(11), .NUM_PORTS(2), .PORT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_instr(d2_instr),
        .flush(d2_flush), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .out_const(d2_out_const), .pc_instr(d2_pc), .alu_instr(d2_alu),
        .registers_instr(d2_regs), .in_mux_sel(d2_in_mux),
        .in_port(d2_in_port), .out_mux_sel(d2_out_mux), .out_port(d2_out_port),
        .illegal(d2_illegal), .illegal_cnt(d2_illegal_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [20:0] mk(input logic [3:0] op, input logic [2:0] s,
                                       input logic [2:0] d, input logic [10:0] c);
        return {op, s, d, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected head fields: pc, alu, regs, in_mux, in_port, out_mux, out_port, const
    task automatic chk_head(input string tag, input logic [3:0] pc, input logic [1:0] alu,
                            input logic [1:0] regs, input logic [1:0] im, input logic [1:0] ip,
                            input logic om, input logic [1:0] op, input logic [10:0] c);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".pc"}, 32'(pc_instr), 32'(pc));
        chk({tag, ".alu"}, 32'(alu_instr), 32'(alu));
        chk({tag, ".regs"}, 32'(registers_instr), 32'(regs));
        chk({tag, ".in_mux"}, 32'(in_mux_sel), 32'(im));
        chk({tag, ".in_port"}, 32'(in_port), 32'(ip));
        chk({tag, ".out_mux"}, 32'(out_mux_sel), 32'(om));
        chk({tag, ".out_port"}, 32'(out_port), 32'(op));
        chk({tag, ".const"}, 32'(out_const), 32'(c));
    endtask

    logic [20:0] w1, w2, w3;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
        d2_in_valid = 1'b0; d2_instr = '0; d2_flush = 1'b0; d2_out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.illegal", 32'(illegal), 32'd0);
        chk("rst.cnt", 32'(illegal_cnt), 32'd0);
        chk("rst.pc", 32'(pc_instr), 32'd0);
        chk("rst.const", 32'(out_const), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk("rst.in_ready_up", 32'(in_ready), 32'd1);

        // MOV 5, ACC
        in_valid = 1'b1; in_instr = mk(4'd1, 3'd2, 3'd1, 11'd5); out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_head("mov_imm", 4'd0, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 2'd0, 11'd5);
        tick();
        chk("mov_imm.drained", 32'(out_valid), 32'd0);

        // Back-pressure: three words, out_ready low
        w1 = mk(4'd4, 3'd6, 3'd0, 11'd9);   // ADD port3 (const field ignored)
        w2 = mk(4'd1, 3'd1, 3'd3, 11'd0);   // MOV ACC, port1
        w3 = mk(4'd7, 3'd0, 3'd0, 11'd100); // JMP 100
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = w1;
        tick();
        chk("bp.ready1", 32'(in_ready), 32'd1);
        chk_head("add_port3", 4'd0, 2'd1, 2'd1, 2'd3, 2'd3, 1'b0, 2'd0, 11'd0);
        in_instr = w2;
        tick();
        chk("bp.ready2", 32'(in_ready), 32'd0);
        in_instr = w3;
        tick();
        chk("bp.ready3", 32'(in_ready), 32'd0);
        chk_head("bp.hold_w1", 4'd0, 2'd1, 2'd1, 2'd3, 2'd3, 1'b0, 2'd0, 11'd0);
        out_ready = 1'b1;
        tick();
        chk_head("bp.w2", 4'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b1, 2'd1, 11'd0);
        chk("bp.ready_back", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk_head("bp.w3", 4'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 11'd100);
        tick();
        chk("bp.empty", 32'(out_valid), 32'd0);

        // JRO with IMM source, offset -3
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = mk(4'd12, 3'd2, 3'd0, 11'h7FD);
        tick();
        chk_head("jro_imm", 4'd6, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 11'h7FD);

        // Fill to two entries, then flush with a beat on the input
        in_instr = mk(4'd5, 3'd1, 3'd0, 11'd0);
        tick();
        chk("fl.full", 32'(in_ready), 32'd0);
        in_instr = mk(4'd13, 3'd0, 3'd0, 11'd0);
        flush = 1'b1;
        tick();
        chk("fl.out_valid", 32'(out_valid), 32'd0);
        chk("fl.in_ready", 32'(in_ready), 32'd1);
        chk("fl.pc_cleared", 32'(pc_instr), 32'd0);
        // Flush while empty and ready: the illegal beat must be dropped uncounted
        tick();
        chk("fl.drop_valid", 32'(out_valid), 32'd0);
        chk("fl.drop_illegal", 32'(illegal), 32'd0);
        chk("fl.drop_cnt", 32'(illegal_cnt), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl.never_out", 32'(out_valid), 32'd0);

        // NEG: no IMM source, so out_const must be 0 despite a const field
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = mk(4'd6, 3'd2, 3'd0, 11'd7);
        tick();
        in_valid = 1'b0;
        chk_head("neg", 4'd0, 2'd3, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0, 11'd0);
        tick();

        // Same ADD port3 word on a 2-port instance is illegal
        d2_out_ready = 1'b1;
        d2_in_valid = 1'b1; d2_instr = w1;
        tick();
        d2_in_valid = 1'b0;
        chk("np2.valid", 32'(d2_out_valid), 32'd1);
        chk("np2.in_mux", 32'(d2_in_mux), 32'd0);
        chk("np2.alu", 32'(d2_alu), 32'd0);
        chk("np2.regs", 32'(d2_regs), 32'd0);
        chk("np2.illegal", 32'(d2_illegal), 32'd1);
        chk("np2.cnt", 32'(d2_illegal_cnt), 32'd1);
        tick();

        // 300 opcode-15 words: counter saturates at 255
        in_valid = 1'b1; in_instr = mk(4'd15, 3'd0, 3'd0, 11'd0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 99) chk("sat.cnt100", 32'(illegal_cnt), 32'd100);
            if (i == 254) chk("sat.cnt255", 32'(illegal_cnt), 32'd255);
        end
        chk("sat.cnt_final", 32'(illegal_cnt), 32'd255);
        chk("sat.illegal", 32'(illegal), 32'd1);
        chk("sat.valid", 32'(out_valid), 32'd1);
        chk("sat.pc_nop", 32'(pc_instr), 32'd0);
        chk("sat.ready", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-burst, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.in_ready", 32'(in_ready), 32'd0);
        chk("arst.illegal", 32'(illegal), 32'd0);
        chk("arst.cnt", 32'(illegal_cnt), 32'd0);
        chk("arst.d2_cnt", 32'(d2_illegal_cnt), 32'd0);
        in_valid = 1'b0;
        #10;
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst.recover_ready", 32'(in_ready), 32'd1);
        chk("arst.recover_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
